// File: rtl/handshaked_reg_pipe_if.sv
// Ready/valid channel: one data word, a valid flag and a ready flag.
// The master drives data and vld. The slave drives rd.
interface handshaked_reg_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  vld;
  logic                  rd;

  modport master (output data, output vld, input rd);
  modport slave  (input data, input vld, output rd);
endinterface

// File: rtl/handshaked_reg_pipe.sv
// DEPTH chained skid stages on a ready/valid channel. Latency is DEPTH edges and the pipe sustains one word per cycle.
// Each stage's rd, vld and data are registered. A downstream stall fills the pipe (2*DEPTH words) before dataIn_rd drops.
module handshaked_reg_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int OCC_WIDTH  = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  handshaked_reg_pipe_if.slave     dataIn,
  handshaked_reg_pipe_if.master    dataOut,
  output logic [OCC_WIDTH-1:0]     occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stageState_t;

  if (DEPTH == 0) begin : gWire
    assign dataOut.data = dataIn.data;
    assign dataOut.vld  = dataIn.vld;
    assign dataIn.rd    = dataOut.rd;
    assign occupancy    = '0;
  end else begin : gPipe
    // Index k is the input side of stage k. Index DEPTH is the pipe output.
    logic [DEPTH:0][DATA_WIDTH-1:0] chainData;
    logic [DEPTH:0]                 chainVld;
    logic [DEPTH:0]                 chainRd;
    logic                           topIn;
    logic                           topOut;
    logic [OCC_WIDTH-1:0]           occ;

    assign chainData[0]   = dataIn.data;
    assign chainVld[0]    = dataIn.vld;
    assign chainRd[DEPTH] = dataOut.rd;

    assign dataOut.data = chainData[DEPTH];
    assign dataOut.vld  = chainVld[DEPTH];
    // Upstream sees "not ready" for as long as reset is held.
    assign dataIn.rd    = rst_n & chainRd[0];

    for (genvar k = 0; k < DEPTH; k++) begin : gStage
      stageState_t           state;
      logic [DATA_WIDTH-1:0] mainData;
      logic [DATA_WIDTH-1:0] skidData;
      logic                  inXfer;
      logic                  outXfer;

      assign inXfer  = chainVld[k] & chainRd[k];
      assign outXfer = chainVld[k+1] & chainRd[k+1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state    <= EMPTY;
          mainData <= '0;
          skidData <= '0;
        end else begin
          case (state)
            EMPTY: begin
              if (inXfer) begin
                mainData <= chainData[k];
                state    <= ONE;
              end
            end
            ONE: begin
              if (inXfer && outXfer) begin
                mainData <= chainData[k];
              end else if (inXfer) begin
                skidData <= chainData[k];
                state    <= FULL;
              end else if (outXfer) begin
                state <= EMPTY;
              end
            end
            FULL: begin
              // A full stage cannot accept input, because its rd is low.
              if (outXfer) begin
                mainData <= skidData;
                state    <= ONE;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

      assign chainData[k+1] = mainData;
      assign chainVld[k+1]  = (state != EMPTY);
      assign chainRd[k]     = (state != FULL);
    end

    assign topIn  = dataIn.vld & dataIn.rd;
    assign topOut = dataOut.vld & dataOut.rd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ <= '0;
      end else if (topIn && !topOut) begin
        occ <= occ + OCC_WIDTH'(1);
      end else if (!topIn && topOut) begin
        occ <= occ - OCC_WIDTH'(1);
      end
    end

    assign occupancy = occ;
  end

endmodule

// File: tb/tb_handshaked_reg_pipe.sv
// Directed bench for handshaked_reg_pipe. It instantiates three DUTs with DEPTH=2, DEPTH=3 and DEPTH=0.
// The DEPTH=3 instance also gets a randomised run checked against a scoreboard.
module tb_handshaked_reg_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) aIn();
  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) aOut();
  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) bIn();
  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) bOut();
  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) cIn();
  handshaked_reg_pipe_if #(.DATA_WIDTH(8)) cOut();

  logic [2:0] occA;
  logic [2:0] occB;
  logic [0:0] occC;

  handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .dataIn(aIn), .dataOut(aOut), .occupancy(occA));
  handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(3)) dutB (
    .clk(clk), .rst_n(rst_n), .dataIn(bIn), .dataOut(bOut), .occupancy(occB));
  handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(0)) dutC (
    .clk(clk), .rst_n(rst_n), .dataIn(cIn), .dataOut(cOut), .occupancy(occC));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int outCount;
    int cyc;
    bit hold;
    int acc;
    int taken;
    logic [2:0] drainOcc[5];
    logic       drainRd[5];

    aIn.data = '0; aIn.vld = 0; aOut.rd = 0;
    bIn.data = '0; bIn.vld = 0; bOut.rd = 0;
    cIn.data = '0; cIn.vld = 0; cOut.rd = 0;

    // Reset state while rst_n is low.
    #2;
    chk("rst_in_rd", aIn.rd, 0);
    chk("rst_out_vld", aOut.vld, 0);
    chk("rst_out_data", aOut.data, 0);
    chk("rst_occ", occA, 0);
    chk("rst_occ_b", occB, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_rd", aIn.rd, 1);

    // Test 1: single word, latency of two edges.
    step();
    aIn.data = 8'h11; aIn.vld = 1; aOut.rd = 1;
    step();
    aIn.vld = 0;
    #1;
    chk("t1_vld_early", aOut.vld, 0);
    chk("t1_occ1", occA, 1);
    step();
    chk("t1_vld", aOut.vld, 1);
    chk("t1_data", aOut.data, 8'h11);
    chk("t1_occ_held", occA, 1);
    step();
    chk("t1_vld_gone", aOut.vld, 0);
    chk("t1_occ0", occA, 0);

    // Test 2: back-to-back stream 0x00..0x0F.
    for (int c = 0; c <= 18; c++) begin
      if (c < 16) begin
        aIn.vld = 1; aIn.data = 8'(c);
      end else begin
        aIn.vld = 0;
      end
      #1;
      if (c < 16) chk("t2_in_rd", aIn.rd, 1);
      chk("t2_out_vld", aOut.vld, (c >= 2 && c < 18) ? 1 : 0);
      if (c >= 2 && c < 18) chk("t2_out_data", aOut.data, 32'(c - 2));
      acc   = (c < 16) ? c : 16;
      taken = (c < 2) ? 0 : ((c - 2 < 16) ? c - 2 : 16);
      chk("t2_occ", occA, 32'(acc - taken));
      step();
    end

    // Test 3: stalled output fills after four words, then drains in order.
    aOut.rd = 0;
    for (int c = 0; c < 8; c++) begin
      aIn.vld = 1; aIn.data = 8'((c < 4) ? c : 4);
      #1;
      chk("t3_in_rd", aIn.rd, (c < 4) ? 1 : 0);
      chk("t3_occ", occA, (c < 4) ? c : 4);
      step();
    end
    drainOcc = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    drainRd  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    aIn.vld = 0;
    for (int c = 0; c < 5; c++) begin
      aOut.rd = 1;
      #1;
      chk("t3_drain_in_rd", aIn.rd, drainRd[c]);
      chk("t3_drain_occ", occA, drainOcc[c]);
      chk("t3_drain_vld", aOut.vld, (c < 4) ? 1 : 0);
      if (c < 4) chk("t3_drain_data", aOut.data, c);
      step();
    end

    // Test 4: DEPTH=3 random handshakes against a scoreboard.
    outCount = 0; cyc = 0; hold = 0;
    while (outCount < 1000 && cyc < 20000) begin
      if (!hold) begin
        bIn.vld  = ($urandom_range(0, 1) == 1);
        bIn.data = 8'($urandom);
      end
      bOut.rd = ($urandom_range(0, 1) == 1);
      #1;
      chk("t4_occ", occB, q.size());
      chk("t4_occ_max", (occB <= 3'd6), 1);
      if (bOut.vld && bOut.rd) begin
        if (q.size() == 0) begin
          chk("t4_spurious", bOut.vld, 0);
        end else begin
          chk("t4_data", bOut.data, q[0]);
          void'(q.pop_front());
          outCount++;
        end
      end
      if (bIn.vld && bIn.rd) begin
        q.push_back(bIn.data);
        hold = 0;
      end else begin
        hold = bIn.vld;
      end
      step();
      cyc++;
    end
    chk("t4_word_count", outCount, 1000);
    bIn.vld = 0; bOut.rd = 0;

    // Test 5: asynchronous reset with three words in flight.
    aOut.rd = 0;
    for (int d = 0; d < 3; d++) begin
      aIn.vld = 1; aIn.data = 8'(8'h31 + d);
      step();
    end
    aIn.vld = 0;
    #1;
    chk("t5_occ3", occA, 3);
    chk("t5_head", aOut.data, 8'h31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", aOut.vld, 0);
    chk("t5_rst_occ", occA, 0);
    chk("t5_rst_in_rd", aIn.rd, 0);
    chk("t5_rst_data", aOut.data, 0);
    step();
    #2;
    rst_n = 1'b1;
    #1;
    chk("t5_rel_in_rd", aIn.rd, 1);
    step();
    aIn.data = 8'hA5; aIn.vld = 1; aOut.rd = 1;
    step();
    aIn.vld = 0;
    #1;
    chk("t5_a5_early", aOut.vld, 0);
    step();
    chk("t5_a5_vld", aOut.vld, 1);
    chk("t5_a5_data", aOut.data, 8'hA5);
    step();
    chk("t5_a5_gone", aOut.vld, 0);
    chk("t5_occ_end", occA, 0);

    // Test 6: DEPTH=0 is a combinational wire.
    cIn.data = 8'h5A; cIn.vld = 1; cOut.rd = 0;
    #1;
    chk("t6_data_a", cOut.data, 8'h5A);
    chk("t6_vld_a", cOut.vld, 1);
    chk("t6_rd_a", cIn.rd, 0);
    chk("t6_occ_a", occC, 0);
    cIn.data = 8'hC3; cIn.vld = 0; cOut.rd = 1;
    #1;
    chk("t6_data_b", cOut.data, 8'hC3);
    chk("t6_vld_b", cOut.vld, 0);
    chk("t6_rd_b", cIn.rd, 1);
    chk("t6_occ_b", occC, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
